// File: rtl/us_timer_pkg.sv
// Shared constants for the microsecond timer: state encoding, default widths
// and the run-mode values sampled with start.
package us_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int CNT_W = 16;
    localparam int TCK_W = 8;

    localparam logic MODE_ONE = 1'b0;
    localparam logic MODE_PER = 1'b1;

endpackage : us_timer_pkg

// File: rtl/us_timer.sv
// Programmable microsecond down-counter. It consumes the 1 us strobe, supports
// one-shot and periodic expiry, and keeps a wrapping count of ticks since start.
// Within a cycle stop beats start, and start beats the strobe.
module us_timer
    import us_timer_pkg::*;
#(
    parameter int CNT_W = us_timer_pkg::CNT_W,
    parameter int TCK_W = us_timer_pkg::TCK_W
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             pluse_us,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] cnt_now,
    output logic [TCK_W-1:0] tick_cnt,
    output logic             rej
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TCK_W-1:0] TCK_ONE = {{(TCK_W-1){1'b0}}, 1'b1};

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [CNT_W-1:0]   reload_q,   reload_d;
    logic               mode_q,     mode_d;
    logic [TCK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick_q,     tick_d;
    logic               rej_q,      rej_d;

    // Next-state decode; the expiry branch also covers cnt_q == 0 so a
    // corrupted zero count in RUN cannot wrap to all-ones.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        mode_d     = mode_q;
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        rej_d      = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            if (load_val != '0) begin
                state_d    = ST_RUN;
                cnt_d      = load_val;
                reload_d   = load_val;
                mode_d     = mode;
                tick_cnt_d = '0;
            end else begin
                rej_d = 1'b1;
            end
        end else if (state_q == ST_RUN && pluse_us) begin
            if (cnt_q > CNT_ONE) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                tick_d     = 1'b1;
                tick_cnt_d = tick_cnt_q + TCK_ONE;
                if (mode_q == MODE_PER) begin
                    cnt_d = reload_q;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            reload_q   <= '0;
            mode_q     <= MODE_ONE;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            rej_q      <= rej_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign tick     = tick_q;
    assign cnt_now  = cnt_q;
    assign tick_cnt = tick_cnt_q;
    assign rej      = rej_q;

endmodule : us_timer

// File: tb/tb_us_timer.sv
// Directed bench for us_timer: one task per scenario, each with its own
// hand-computed expectations.
module tb_us_timer;

    localparam int CNT_W = 16;
    localparam int TCK_W = 8;

    logic             clk_sys  = 1'b0;
    logic             rst_n    = 1'b0;
    logic             pluse_us = 1'b0;
    logic             start    = 1'b0;
    logic             stop     = 1'b0;
    logic             mode     = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             busy, tick, rej;
    logic [CNT_W-1:0] cnt_now;
    logic [TCK_W-1:0] tick_cnt;

    int checks   = 0;
    int failures = 0;

    us_timer #(.CNT_W(CNT_W), .TCK_W(TCK_W)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pluse_us(pluse_us),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .load_val(load_val),
        .busy    (busy),
        .tick    (tick),
        .cnt_now (cnt_now),
        .tick_cnt(tick_cnt),
        .rej     (rej)
    );

    always #5 clk_sys = ~clk_sys;

    // One clock cycle with the given inputs; outputs are settled on return.
    task automatic cyc(input logic s, input logic sp, input logic p, input logic m,
                       input logic [CNT_W-1:0] lv);
        start = s; stop = sp; pluse_us = p; mode = m; load_val = lv;
        @(posedge clk_sys); #1;
        start = 1'b0; stop = 1'b0; pluse_us = 1'b0;
    endtask

    // n strobes, each preceded by gap-1 quiet cycles; counts every tick seen.
    task automatic strobes(input int n, input int gap, output int ticks, output logic last_tick);
        ticks = 0; last_tick = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap - 1; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
                if (tick === 1'b1) ticks++;
            end
            cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
            last_tick = tick;
            if (tick === 1'b1) ticks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", tick); end
        checks++; if (cnt_now !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", cnt_now); end
        checks++; if (tick_cnt !== 8'd0) begin failures++; $display("FAIL reset_tickcnt got=%0d want=0", tick_cnt); end
        checks++; if (rej !== 1'b0) begin failures++; $display("FAIL reset_rej got=%b want=0", rej); end
        @(negedge clk_sys); rst_n = 1'b1;
        @(posedge clk_sys); #1;
        $display("test_reset done");
    endtask

    task automatic test_oneshot();
        int t; logic lt;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        checks++; if (busy !== 1'b1 || cnt_now !== 16'd3) begin failures++; $display("FAIL os_start busy=%b cnt=%0d want busy=1 cnt=3", busy, cnt_now); end
        strobes(2, 100, t, lt);
        checks++; if (cnt_now !== 16'd1 || t != 0) begin failures++; $display("FAIL os_mid cnt=%0d ticks=%0d want cnt=1 ticks=0", cnt_now, t); end
        strobes(1, 100, t, lt);
        checks++; if (lt !== 1'b1 || t != 1) begin failures++; $display("FAIL os_tick last=%b ticks=%0d want 1/1", lt, t); end
        checks++; if (busy !== 1'b0 || cnt_now !== 16'd0 || tick_cnt !== 8'd1) begin failures++; $display("FAIL os_end busy=%b cnt=%0d tc=%0d want 0/0/1", busy, cnt_now, tick_cnt); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL os_tick_width got=%b want=0", tick); end
        strobes(2, 10, t, lt);
        checks++; if (t != 0 || busy !== 1'b0) begin failures++; $display("FAIL os_idle_strobe ticks=%0d busy=%b want 0/0", t, busy); end
        $display("test_oneshot done");
    endtask

    task automatic test_periodic();
        int t; logic lt;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
        for (int i = 1; i <= 7; i++) begin
            strobes(1, 100, t, lt);
            checks++; if (lt !== ((i % 2) == 0)) begin failures++; $display("FAIL per_tick%0d got=%b want=%b", i, lt, (i % 2) == 0); end
        end
        checks++; if (busy !== 1'b1 || cnt_now !== 16'd1 || tick_cnt !== 8'd3) begin failures++; $display("FAIL per_end busy=%b cnt=%0d tc=%0d want 1/1/3", busy, cnt_now, tick_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (busy !== 1'b0 || cnt_now !== 16'd0 || tick_cnt !== 8'd3) begin failures++; $display("FAIL per_stop busy=%b cnt=%0d tc=%0d want 0/0/3", busy, cnt_now, tick_cnt); end
        $display("test_periodic done");
    endtask

    task automatic test_stop_collision();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checks++; if (tick !== 1'b0 || busy !== 1'b0 || cnt_now !== 16'd0) begin failures++; $display("FAIL stop_coll tick=%b busy=%b cnt=%0d want 0/0/0", tick, busy, cnt_now); end
        checks++; if (tick_cnt !== 8'd0) begin failures++; $display("FAIL stop_coll_tc got=%0d want=0", tick_cnt); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        checks++; if (rej !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL start_stop_zero rej=%b busy=%b want 0/0", rej, busy); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd7);
        checks++; if (busy !== 1'b0 || cnt_now !== 16'd0) begin failures++; $display("FAIL start_stop busy=%b cnt=%0d want 0/0", busy, cnt_now); end
        $display("test_stop_collision done");
    endtask

    task automatic test_restart();
        int t; logic lt;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'd5);
        checks++; if (cnt_now !== 16'd5) begin failures++; $display("FAIL coinc_cnt got=%0d want=5", cnt_now); end
        strobes(3, 20, t, lt);
        checks++; if (cnt_now !== 16'd2) begin failures++; $display("FAIL restart_pre got=%0d want=2", cnt_now); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
        checks++; if (cnt_now !== 16'd4 || busy !== 1'b1) begin failures++; $display("FAIL restart_load cnt=%0d busy=%b want 4/1", cnt_now, busy); end
        strobes(3, 20, t, lt);
        checks++; if (t != 0 || cnt_now !== 16'd1) begin failures++; $display("FAIL restart_early ticks=%0d cnt=%0d want 0/1", t, cnt_now); end
        strobes(1, 20, t, lt);
        checks++; if (lt !== 1'b1 || tick_cnt !== 8'd1 || busy !== 1'b0) begin failures++; $display("FAIL restart_tick tick=%b tc=%0d busy=%b want 1/1/0", lt, tick_cnt, busy); end
        $display("test_restart done");
    endtask

    task automatic test_reject();
        int t; logic lt;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        checks++; if (rej !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rej_idle rej=%b busy=%b want 1/0", rej, busy); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (rej !== 1'b0) begin failures++; $display("FAIL rej_width got=%b want=0", rej); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        strobes(1, 10, t, lt);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
        checks++; if (rej !== 1'b1 || busy !== 1'b1 || cnt_now !== 16'd2) begin failures++; $display("FAIL rej_run rej=%b busy=%b cnt=%0d want 1/1/2", rej, busy, cnt_now); end
        strobes(2, 10, t, lt);
        checks++; if (lt !== 1'b1 || t != 1 || busy !== 1'b0) begin failures++; $display("FAIL rej_run_end tick=%b ticks=%0d busy=%b want 1/1/0", lt, t, busy); end
        $display("test_reject done");
    endtask

    task automatic test_wrap_reset();
        int t; logic lt;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
        strobes(257, 10, t, lt);
        checks++; if (t != 257 || tick_cnt !== 8'd1) begin failures++; $display("FAIL wrap ticks=%0d tc=%0d want 257/1", t, tick_cnt); end
        checks++; if (busy !== 1'b1 || cnt_now !== 16'd1 || tick !== 1'b1) begin failures++; $display("FAIL wrap_state busy=%b cnt=%0d tick=%b want 1/1/1", busy, cnt_now, tick); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || tick !== 1'b0 || cnt_now !== 16'd0 || tick_cnt !== 8'd0) begin failures++; $display("FAIL async_rst busy=%b tick=%b cnt=%0d tc=%0d want 0", busy, tick, cnt_now, tick_cnt); end
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys); rst_n = 1'b1;
        @(posedge clk_sys); #1;
        strobes(3, 10, t, lt);
        checks++; if (t != 0 || busy !== 1'b0 || tick_cnt !== 8'd0) begin failures++; $display("FAIL post_rst ticks=%0d busy=%b tc=%0d want 0/0/0", t, busy, tick_cnt); end
        $display("test_wrap_reset done");
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_collision();
        test_restart();
        test_reject();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_us_timer

// File: doc/us_timer.md
# us_timer

Programmable microsecond timer in the clk_sys domain, counting the one-cycle 1 µs strobe `pluse_us` from the clock/reset top. A controller loads a count and starts the timer. `us_timer` then decrements once per strobe and raises a one-cycle `tick` on expiry, either once (one-shot) or repeatedly (periodic). It is the consumer end of the `pluse_us` timebase and serves timeouts and periodic service requests in the main FPGA logic.

## Interface
Parameters:
- CNT_W, 16, width of load value and live count
- TCK_W, 8, width of the periodic tick counter

Ports:
- clk_sys  in  1  system clock (100 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- pluse_us  in  1  1 µs strobe, one clk_sys cycle wide, same clock domain
- start  in  1  one-cycle request to (re)start with load_val
- stop  in  1  one-cycle abort request
- mode  in  1  sampled with start: 0 = one-shot, 1 = periodic
- load_val  in  CNT_W  count in µs, sampled with start
- busy  out  1  timer running
- tick  out  1  one-cycle expiry pulse
- cnt_now  out  CNT_W  live remaining count
- tick_cnt  out  TCK_W  ticks since last start; wraps
- rej  out  1  one-cycle pulse: start with load_val == 0 rejected

## Operation
- State machine with two states, IDLE and RUN.
- Registers: state, cnt, reload, mode_r, tick_cnt.
- Priority order within a cycle: stop > start > pluse_us.
- stop (any state):
  - Go to IDLE; cnt = 0.
  - tick stays 0 even if pluse_us would have expired the count that cycle.
  - tick_cnt holds its value.
- start with load_val != 0 (IDLE or RUN):
  - Go to RUN; cnt = reload = load_val; mode_r = mode; tick_cnt = 0.
  - A pluse_us in the same cycle is ignored and does not decrement.
  - In RUN this is a restart with the new value.
- start with load_val == 0:
  - State, cnt, reload and mode_r are unchanged.
  - rej pulses for one cycle (registered).
- RUN with pluse_us, no start, no stop:
  - cnt > 1: cnt = cnt − 1.
  - cnt == 1, one-shot: tick; go to IDLE; cnt = 0; tick_cnt + 1.
  - cnt == 1, periodic: tick; cnt = reload; stay in RUN; tick_cnt + 1.
- tick_cnt is unsigned, modulo 2^TCK_W: 255 + 1 = 0 for the default width, with no flag.
- In IDLE, pluse_us has no effect.
- busy = (state == RUN).

## Timing
- All outputs are registered.
- Reset values: busy 0, tick 0, cnt_now 0, tick_cnt 0, rej 0; state IDLE; reload 0; mode_r 0.
- busy rises in the cycle after the start cycle and falls in the cycle after a stop or one-shot expiry.
- cnt_now reflects the new cnt one cycle after the causing event.
- Expiry latency: start in cycle 0 with load N. Count the pluse_us strobes occurring in cycles > 0. tick is high in the cycle after the N-th such strobe.
- rej is high in the cycle after the rejected start.
- Periodic period is exactly reload strobes: consecutive ticks are reload × 100 clk_sys cycles apart with nominal pluse_us.
- Reset asserted mid-run: all registers go to reset values immediately (asynchronously). No tick is produced. After release the block waits in IDLE for start.
- start and stop together: stop wins; IDLE; no rej, even if load_val == 0.

## Structure
- Shared package holds:
  - State encoding: ST_IDLE = 1'b0, ST_RUN = 1'b1.
  - Default widths CNT_W = 16, TCK_W = 8.
  - Mode constants MODE_ONE = 1'b0, MODE_PER = 1'b1.
- Single module; no sub-module. The down-counter and FSM are small enough to keep together.
- Strobe generation stays in the existing pulse generator; this block only consumes it.

## Test plan
- One-shot: load 3, mode 0; strobes every 100 cycles → one tick one cycle after the 3rd strobe; busy falls with it; cnt_now = 0; tick_cnt = 1.
- Periodic: load 2, mode 1; run 7 strobes → ticks after strobes 2, 4 and 6; busy stays 1; cnt_now = 1 after the 7th strobe; tick_cnt = 3.
- Stop collision: load 1, then stop in the same cycle as the expiring strobe → no tick; busy = 0; cnt_now = 0.
- Restart/coincidence: start with load 5 in the same cycle as a strobe → cnt_now = 5, not 4. Restart at count 2 with load 4 → tick only after 4 further strobes.
- Reject: start with load 0 while IDLE → rej = 1 for one cycle; busy stays 0. Start with load 0 while RUN → rej = 1; run continues unchanged.
- Wrap and reset: periodic, load 1, 257 strobes → tick_cnt = 1. Assert rst_n low mid-run → busy, tick, cnt_now and tick_cnt are 0 within the same cycle. No tick after release until a new start.
